// File: rtl/button_debouncer.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM, clean level plus press/release/hold pulses.
// Define HOLD_DETECT_EN to build the long-press counter; otherwise BTN_HOLD is tied low.
module button_debouncer #(
    parameter int DEBOUNCE_LIMIT = 120000,
    parameter int HOLD_LIMIT     = 12000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_RAW,
    output logic BTN_LEVEL,
    output logic BTN_PRESS,
    output logic BTN_RELEASE,
    output logic BTN_HOLD
);

    localparam int DW = $clog2(DEBOUNCE_LIMIT);
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_LIMIT - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic          sync1, sync2;
    logic [DW-1:0] dcnt, dcnt_nx;
    logic          level_nx, press_nx, release_nx;
    logic          d_done;

    assign d_done = (dcnt == DMAX);

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            state       <= IDLE;
            dcnt        <= '0;
            BTN_LEVEL   <= 1'b0;
            BTN_PRESS   <= 1'b0;
            BTN_RELEASE <= 1'b0;
        end else begin
            sync1       <= BTN_RAW;
            sync2       <= sync1;
            state       <= state_nx;
            dcnt        <= dcnt_nx;
            BTN_LEVEL   <= level_nx;
            BTN_PRESS   <= press_nx;
            BTN_RELEASE <= release_nx;
        end
    end

    // Any reversal of sync2 during a WAIT state abandons the qualification.
    always_comb begin
        state_nx = state;
        dcnt_nx  = dcnt;
        case (state)
            IDLE: begin
                if (sync2) begin
                    state_nx = PRESS_WAIT;
                    dcnt_nx  = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync2)      state_nx = IDLE;
                else if (d_done) state_nx = PRESSED;
                else             dcnt_nx  = dcnt + 1'b1;
            end
            PRESSED: begin
                if (!sync2) begin
                    state_nx = RELEASE_WAIT;
                    dcnt_nx  = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync2)       state_nx = PRESSED;
                else if (d_done) state_nx = IDLE;
                else             dcnt_nx  = dcnt + 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        level_nx   = BTN_LEVEL;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        case (state)
            PRESS_WAIT: begin
                if (sync2 && d_done) begin
                    level_nx = 1'b1;
                    press_nx = 1'b1;
                end
            end
            RELEASE_WAIT: begin
                if (!sync2 && d_done) begin
                    level_nx   = 1'b0;
                    release_nx = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef HOLD_DETECT_EN
    localparam int HW = $clog2(HOLD_LIMIT);
    localparam logic [HW-1:0] HMAX = HW'(HOLD_LIMIT - 1);

    logic [HW-1:0] hcnt;
    logic          hold_done;

    // hcnt parks at HMAX; hold_done keeps the pulse to once per press.
    // Nothing counts outside PRESSED, so a bounce only pauses the count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hcnt      <= '0;
            hold_done <= 1'b0;
            BTN_HOLD  <= 1'b0;
        end else begin
            BTN_HOLD <= 1'b0;
            if (press_nx) begin
                hcnt      <= '0;
                hold_done <= 1'b0;
            end else if (state == PRESSED && sync2) begin
                if (hcnt == HMAX) begin
                    if (!hold_done) begin
                        BTN_HOLD  <= 1'b1;
                        hold_done <= 1'b1;
                    end
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end
    end
`else
    logic unused_hold_limit;
    assign unused_hold_limit = (HOLD_LIMIT != 0);
    assign BTN_HOLD = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer with DEBOUNCE_LIMIT=4, HOLD_LIMIT=20: table vectors, corner sequences,
// and random bouncing input against a run-length reference model.
module tb_button_debouncer;

    localparam int DL = 4;
    localparam int HL = 20;
`ifdef HOLD_DETECT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic RST = 1'b1;
    logic BTN_RAW = 1'b0;
    logic BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_HOLD;

    always #42 clk = ~clk;

    button_debouncer #(.DEBOUNCE_LIMIT(DL), .HOLD_LIMIT(HL)) dut (
        .CLK(clk), .RST(RST), .BTN_RAW(BTN_RAW),
        .BTN_LEVEL(BTN_LEVEL), .BTN_PRESS(BTN_PRESS),
        .BTN_RELEASE(BTN_RELEASE), .BTN_HOLD(BTN_HOLD)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // Reference model: the pin delayed by two samples, a qualified level and a
    // count of consecutive samples disagreeing with it (L+1 of them flip it).
    logic m_d1, m_d2, m_lvl, m_press, m_rel, m_hold, m_hfired;
    int   m_run, m_ht;

    task automatic model_step(input logic rst, input logic raw);
        logic s;
        if (rst) begin
            m_d1 = 0; m_d2 = 0; m_lvl = 0; m_run = 0; m_ht = 0; m_hfired = 0;
            m_press = 0; m_rel = 0; m_hold = 0;
        end else begin
            s = m_d2;
            m_press = 0; m_rel = 0; m_hold = 0;
            // Hold time accrues only on samples taken while settled pressed.
            if (m_lvl && m_run == 0 && s && !m_hfired) begin
                m_ht++;
                if (m_ht == HL) begin
                    m_hold = HOLD_EN;
                    m_hfired = 1;
                end
            end
            if (s != m_lvl) begin
                m_run++;
                if (m_run == DL + 1) begin
                    m_lvl = s;
                    m_run = 0;
                    if (s) begin
                        m_press = 1; m_ht = 0; m_hfired = 0;
                    end else begin
                        m_rel = 1;
                    end
                end
            end else begin
                m_run = 0;
            end
            m_d2 = m_d1;
            m_d1 = raw;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input logic rst, input logic raw);
        @(negedge clk);
        RST = rst;
        BTN_RAW = raw;
        @(posedge clk);
        model_step(rst, raw);
        cyc++;
        #1;
    endtask

    task automatic check_model();
        chk("level", int'(BTN_LEVEL), int'(m_lvl));
        chk("press", int'(BTN_PRESS), int'(m_press));
        chk("release", int'(BTN_RELEASE), int'(m_rel));
        chk("hold", int'(BTN_HOLD), int'(m_hold));
    endtask

    // Event log for the hand-written sequences; indices count edges from seq_start.
    int seq_idx, press_n, rel_n, hold_n, lvl_n, press_at, rel_at, hold_at;

    task automatic seq_start();
        seq_idx = 0; press_n = 0; rel_n = 0; hold_n = 0; lvl_n = 0;
        press_at = -1; rel_at = -1; hold_at = -1;
    endtask

    task automatic drive(input logic rst, input logic raw, input int n);
        for (int k = 0; k < n; k++) begin
            tick(rst, raw);
            check_model();
            if (BTN_PRESS)   begin press_n++; press_at = seq_idx; end
            if (BTN_RELEASE) begin rel_n++;   rel_at = seq_idx;   end
            if (BTN_HOLD)    begin hold_n++;  hold_at = seq_idx;  end
            if (BTN_LEVEL)   lvl_n++;
            seq_idx++;
        end
    endtask

    typedef struct {
        logic       rst;
        logic       raw;
        logic [3:0] exp;   // {level, press, release, hold}
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic rst, input logic raw, input logic [3:0] exp, input int n);
        vec_t v;
        v.rst = rst; v.raw = raw; v.exp = exp;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endfunction

    initial begin
        // Reset held with the button down, then a clean 10-cycle press and release.
        add(1, 1, 4'b0000, 3);
        add(0, 1, 4'b0000, 6);
        add(0, 1, 4'b1100, 1);
        add(0, 1, 4'b1000, 3);
        add(0, 0, 4'b1000, 6);
        add(0, 0, 4'b0010, 1);
        add(0, 0, 4'b0000, 3);

        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].rst, tbl[i].raw);
            chk("tbl_level", int'(BTN_LEVEL), int'(tbl[i].exp[3]));
            chk("tbl_press", int'(BTN_PRESS), int'(tbl[i].exp[2]));
            chk("tbl_release", int'(BTN_RELEASE), int'(tbl[i].exp[1]));
            chk("tbl_hold", int'(BTN_HOLD), int'(tbl[i].exp[0]));
        end

        // Bounce 1,0,1,0 then settle high: one press, 6 edges after the settling edge.
        drive(1, 0, 2);
        seq_start();
        drive(0, 1, 1); drive(0, 0, 1); drive(0, 1, 1); drive(0, 0, 1);
        drive(0, 1, 14);
        chk("bounce_press_n", press_n, 1);
        chk("bounce_press_at", press_at, 10);
        chk("bounce_rel_n", rel_n, 0);

        // A 2-cycle pulse alone is rejected.
        drive(1, 0, 2);
        seq_start();
        drive(0, 1, 2);
        drive(0, 0, 12);
        chk("pulse_press_n", press_n, 0);
        chk("pulse_rel_n", rel_n, 0);
        chk("pulse_lvl_n", lvl_n, 0);

        // Long press for 40 cycles.
        drive(1, 0, 2);
        seq_start();
        drive(0, 1, 40);
        drive(0, 0, 10);
        chk("long_press_at", press_at, 6);
        chk("long_hold_n", hold_n, HOLD_EN ? 1 : 0);
        chk("long_hold_at", hold_at, HOLD_EN ? 26 : -1);
        chk("long_rel_n", rel_n, 1);
        chk("long_rel_at", rel_at, 46);
        chk("long_lvl_n", lvl_n, 40);

        // 2-cycle low blip while pressed: no release, hold delayed by 3 edges.
        drive(1, 0, 2);
        seq_start();
        drive(0, 1, 10);
        drive(0, 0, 2);
        drive(0, 1, 30);
        drive(0, 0, 10);
        chk("glitch_press_n", press_n, 1);
        chk("glitch_rel_n", rel_n, 1);
        chk("glitch_rel_at", rel_at, 48);
        chk("glitch_lvl_n", lvl_n, 42);
        chk("glitch_hold_at", hold_at, HOLD_EN ? 29 : -1);

        // Random runs of bouncing and held input with occasional reset.
        begin
            logic raw;
            int   len;
            raw = 0;
            for (int r = 0; r < 200; r++) begin
                raw = ~raw;
                len = ($urandom_range(0, 3) == 0) ? $urandom_range(18, 40) : $urandom_range(1, 8);
                for (int k = 0; k < len; k++) begin
                    tick(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0, raw);
                    check_model();
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
